// File: rtl/wbc_rr_arbiter_if.sv
// Control-bus arbitration bundle: per-master requests and post-mux slave
// handshake in, grant and watchdog status out.
interface wbc_rr_arbiter_if #(
  parameter int NMASTERS = 4,
  parameter int IW       = $clog2(NMASTERS)
);
  logic [NMASTERS-1:0] cyc;
  logic                s_stb;
  logic                s_ack;
  logic                s_err;
  logic                s_rty;
  logic [NMASTERS-1:0] gnt;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_valid;
  logic                timeout_err;
  logic [7:0]          timeout_cnt;

  // The arbiter side drives grants and watchdog status.
  modport master (
    input  cyc, s_stb, s_ack, s_err, s_rty,
    output gnt, gnt_idx, gnt_valid, timeout_err, timeout_cnt
  );

  // The interconnect side drives requests and the muxed slave response.
  modport slave (
    output cyc, s_stb, s_ack, s_err, s_rty,
    input  gnt, gnt_idx, gnt_valid, timeout_err, timeout_cnt
  );
endinterface

// File: rtl/wbc_rr_arbiter.sv
// Round-robin owner selection for the shared control bus, with a watchdog that
// forces an error termination when the addressed slave never answers.
module wbc_rr_arbiter #(
  parameter int NMASTERS = 4,
  parameter int TIMEOUT  = 255,
  parameter int IW       = $clog2(NMASTERS)
) (
  input  logic               clk,
  input  logic               rst,
  wbc_rr_arbiter_if.master   bus
);

  localparam int             WDW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit             WD_EN   = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, GRANT, TOUT, RELEASE} state_t;

  state_t              state_reg;
  logic [NMASTERS-1:0] gnt_reg;
  logic [IW-1:0]       gnt_idx_reg;
  logic                gnt_valid_reg;
  logic                timeout_err_reg;
  logic [7:0]          timeout_cnt_reg;
  logic [WDW-1:0]      wd_cnt_reg;
  logic [IW-1:0]       last_reg;

  logic                win_found;
  logic [IW-1:0]       win_idx;
  logic [NMASTERS-1:0] win_onehot;
  logic                resp;

  assign resp = bus.s_ack | bus.s_err | bus.s_rty;

  // Search starts just after the previous winner, so the last owner ranks lowest.
  always_comb begin
    logic [IW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NMASTERS; i++) begin
      cand = IW'((int'(last_reg) + i) % NMASTERS);
      if (!win_found && bus.cyc[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  for (genvar gi = 0; gi < NMASTERS; gi++) begin : g_onehot
    assign win_onehot[gi] = (win_idx == IW'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      gnt_reg         <= '0;
      gnt_idx_reg     <= '0;
      gnt_valid_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
      timeout_cnt_reg <= 8'd0;
      wd_cnt_reg      <= '0;
      last_reg        <= IW'(NMASTERS - 1);
    end else begin
      timeout_err_reg <= 1'b0;
      case (state_reg)
        // The release cycle is the dead cycle; arbitration there keeps the gap at one.
        IDLE, RELEASE: begin
          wd_cnt_reg <= '0;
          if (win_found) begin
            gnt_reg       <= win_onehot;
            gnt_idx_reg   <= win_idx;
            gnt_valid_reg <= 1'b1;
            last_reg      <= win_idx;
            state_reg     <= GRANT;
          end else begin
            state_reg     <= IDLE;
          end
        end
        GRANT: begin
          if (!bus.cyc[gnt_idx_reg]) begin
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            wd_cnt_reg    <= '0;
            state_reg     <= RELEASE;
          end else if (WD_EN && bus.s_stb && !resp) begin
            if (wd_cnt_reg == WD_LAST) begin
              wd_cnt_reg      <= '0;
              timeout_err_reg <= 1'b1;
              if (timeout_cnt_reg != 8'hFF)
                timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
              state_reg       <= TOUT;
            end else begin
              wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
          end else begin
            wd_cnt_reg <= '0;
          end
        end
        TOUT: begin
          wd_cnt_reg <= '0;
          state_reg  <= GRANT;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gnt         = gnt_reg;
  assign bus.gnt_idx     = gnt_idx_reg;
  assign bus.gnt_valid   = gnt_valid_reg;
  assign bus.timeout_err = timeout_err_reg;
  assign bus.timeout_cnt = timeout_cnt_reg;

endmodule
